// File: rtl/grom8_mem_pkg.sv
// Shared types and widths for the grom8 RAM arbiter.
// Holds the bus widths, the arbiter FSM states and the bus-owner encoding.
package grom8_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive CPU grants taken while DMA was waiting.
// Ports: clk, reset (sync, active-high), inc, clr (clr wins), at_limit.
module starve_counter #(
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign at_limit = (count_q == CNT_W'(STARVE_LIMIT));

    // Increment stops at the limit so the force-to-DMA condition stays
    // asserted until a DMA grant clears it.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !at_limit) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between a CPU and a DMA master (CPU priority,
// DMA starvation bound). Ports: cpu_*/dma_* req/ack masters, mem_* RAM pins.
module mem_arbiter
    import grom8_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    output logic              mem_memreq,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_memreq_q, mem_memreq_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;

    logic at_limit;
    logic grant_cpu;
    logic grant_dma;
    logic in_idle;
    logic starve_inc;
    logic starve_clr;

    // DMA takes the bus when alone, or when the CPU has already been
    // granted STARVE_LIMIT times in a row while DMA was waiting.
    always_comb begin
        grant_dma = dma_req && (!cpu_req || at_limit);
        grant_cpu = cpu_req && !grant_dma;
    end

    assign in_idle    = (state_q == IDLE);
    assign starve_inc = in_idle && grant_cpu && dma_req;
    assign starve_clr = in_idle && (grant_dma || (grant_cpu && !dma_req));

    starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .inc     (starve_inc),
        .clr     (starve_clr),
        .at_limit(at_limit)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_we_d      = 1'b0;
        mem_memreq_d  = 1'b0;
        cpu_ack_d     = 1'b0;
        dma_ack_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_dma) begin
                    owner_d       = OWN_DMA;
                    mem_addr_d    = dma_addr;
                    mem_data_in_d = dma_wdata;
                    mem_we_d      = dma_we;
                    mem_memreq_d  = 1'b1;
                    state_d       = ACCESS;
                end else if (grant_cpu) begin
                    owner_d       = OWN_CPU;
                    mem_addr_d    = cpu_addr;
                    mem_data_in_d = cpu_wdata;
                    mem_we_d      = cpu_we;
                    mem_memreq_d  = 1'b1;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                // RAM samples at the end of this cycle; the ack follows
                // in RESP, alongside the registered read data.
                cpu_ack_d = (owner_q == OWN_CPU);
                dma_ack_d = (owner_q == OWN_DMA);
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_CPU;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
            mem_memreq_q  <= 1'b0;
            cpu_ack_q     <= 1'b0;
            dma_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
            mem_memreq_q  <= mem_memreq_d;
            cpu_ack_q     <= cpu_ack_d;
            dma_ack_q     <= dma_ack_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_we      = mem_we_q;
    assign mem_memreq  = mem_memreq_q;
    assign cpu_ack     = cpu_ack_q;
    assign dma_ack     = dma_ack_q;

    // Read data is unregistered here: the RAM already registers data_out.
    assign cpu_rdata = mem_data_out;
    assign dma_rdata = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM and a
// transaction-level arbitration model checked every cycle.
module tb_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [11:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data_in;
    logic        mem_we, mem_memreq;
    logic [7:0]  mem_data_out = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .mem_memreq(mem_memreq), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: one-cycle registered read, write on memreq & we
    logic [7:0] ram [4096];
    always @(posedge clk) begin
        if (mem_memreq) begin
            if (mem_we) ram[mem_addr] <= mem_data_in;
            mem_data_out <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d actual=timeout required=ack", nm, cyc);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mmem [4096];
    logic        p_valid = 1'b0, p_dma = 1'b0, p_we = 1'b0;
    int          p_cyc = 0;
    logic [11:0] p_addr = '0;
    logic [7:0]  p_data = '0;
    logic        a_valid = 1'b0, a_dma = 1'b0, a_we = 1'b0;
    int          a_cyc = 0;
    logic [7:0]  a_rd = '0;
    logic [11:0] m_addr = '0;
    logic [7:0]  m_din = '0;
    int          m_free = 0;
    int          m_starve = 0;
    logic        e_acc, e_cack, e_dack;

    always @(negedge clk) begin
        e_acc  = p_valid && p_cyc == cyc;
        e_cack = a_valid && a_cyc == cyc && !a_dma;
        e_dack = a_valid && a_cyc == cyc && a_dma;
        if (e_acc) begin
            m_addr = p_addr;
            m_din  = p_data;
        end
        if (cyc > 0) begin
            chk("mem_memreq", 32'(mem_memreq), 32'(e_acc));
            chk("mem_we", 32'(mem_we), 32'(e_acc && p_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_data_in", 32'(mem_data_in), 32'(m_din));
            chk("cpu_ack", 32'(cpu_ack), 32'(e_cack));
            chk("dma_ack", 32'(dma_ack), 32'(e_dack));
            if (e_cack && !a_we) chk("cpu_rdata", 32'(cpu_rdata), 32'(a_rd));
            if (e_dack && !a_we) chk("dma_rdata", 32'(dma_rdata), 32'(a_rd));
        end
        if (e_acc) begin
            a_rd = mmem[p_addr];
            if (p_we) mmem[p_addr] = p_data;
            a_valid = 1'b1;
            a_cyc   = cyc + 1;
            a_dma   = p_dma;
            a_we    = p_we;
            p_valid = 1'b0;
        end
        if (a_valid && a_cyc <= cyc) a_valid = 1'b0;
        if (reset) begin
            p_valid  = 1'b0;
            a_valid  = 1'b0;
            m_addr   = '0;
            m_din    = '0;
            m_starve = 0;
            m_free   = cyc + 1;
        end else if (cyc >= m_free && (cpu_req || dma_req)) begin
            p_dma = dma_req && (!cpu_req || m_starve == LIM);
            if (p_dma) begin
                p_we = dma_we; p_addr = dma_addr; p_data = dma_wdata;
                m_starve = 0;
            end else begin
                p_we = cpu_we; p_addr = cpu_addr; p_data = cpu_wdata;
                if (!dma_req) m_starve = 0;
                else if (m_starve < LIM) m_starve = m_starve + 1;
            end
            p_valid = 1'b1;
            p_cyc   = cyc + 1;
            m_free  = cyc + 3;
        end
    end

    // event counters for literal checks
    int n_cack = 0, n_dack = 0, n_busy = 0;
    always @(negedge clk) begin
        if (cpu_ack === 1'b1) n_cack++;
        if (dma_ack === 1'b1) n_dack++;
        if (mem_memreq !== 1'b0 || mem_we !== 1'b0) n_busy++;
    end

    // ---------------- stimulus ----------------
    task automatic xfer(input bit is_dma, input logic we,
                        input logic [11:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int n0,
                        output int ackc);
        rd = '0;
        ackc = -1;
        n0 = cyc;
        if (is_dma) begin
            dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_dma && dma_ack) begin
                ackc = cyc; rd = dma_rdata; break;
            end
            if (!is_dma && cpu_ack) begin
                ackc = cyc; rd = cpu_rdata; break;
            end
        end
        @(posedge clk);
        #1;
        if (is_dma) dma_req = 1'b0;
        else cpu_req = 1'b0;
        if (ackc < 0) tmo(is_dma ? "dma_xfer" : "cpu_xfer");
    endtask

    int         st_ack [8];
    logic [7:0] st_rd [8];

    task automatic cpu_stream(input int n, input logic [11:0] base);
        int t;
        cpu_we = 1'b0; cpu_addr = base; cpu_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            st_ack[k] = -1;
            st_rd[k] = '0;
            t = 0;
            while (st_ack[k] < 0 && t < 40) begin
                @(negedge clk);
                t++;
                if (cpu_ack) begin
                    st_ack[k] = cyc; st_rd[k] = cpu_rdata;
                end
            end
            @(posedge clk);
            #1;
            if (st_ack[k] < 0) begin
                tmo("cpu_stream");
                break;
            end
            cpu_addr = base + 12'(k + 1);
        end
        cpu_req = 1'b0;
    endtask

    logic [7:0] rd, rd2;
    int n0, ac, n1, ac2, nd0, nc0;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = '0;
            mmem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_memreq", 32'(mem_memreq), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_acks", 32'({cpu_ack, dma_ack}), 0);
        @(posedge clk);
        #1;

        // CPU write then read
        nd0 = n_dack;
        xfer(0, 1'b1, 12'h123, 8'h5A, rd, n0, ac);
        chk("wr_latency", 32'(ac - n0), 2);
        xfer(0, 1'b0, 12'h123, 8'h00, rd, n0, ac);
        chk("rd_latency", 32'(ac - n0), 2);
        chk("rd_5a", 32'(rd), 32'h5A);
        chk("no_dma_ack", 32'(n_dack - nd0), 0);

        // simultaneous requests: CPU first, DMA after CPU drops
        fork
            xfer(0, 1'b0, 12'h123, 8'h00, rd, n0, ac);
            xfer(1, 1'b1, 12'h200, 8'h33, rd2, n1, ac2);
        join
        chk("sim_cpu_lat", 32'(ac - n0), 2);
        chk("sim_dma_after", 32'(ac2 - ac), 3);

        // starvation
        xfer(1, 1'b1, 12'hD00, 8'hC3, rd, n0, ac);
        nc0 = n_cack;
        fork
            cpu_stream(6, 12'h400);
            xfer(1, 1'b0, 12'hD00, 8'h00, rd2, n1, ac2);
        join
        chk("starve_cpu_before", 32'(n_cack - nc0 - 2), 4);
        chk("starve_4th_cpu", 32'(st_ack[3]), 32'(ac2 - 3));
        chk("starve_dma_wait", 32'(ac2 - n1), 14);
        chk("starve_resume", 32'(st_ack[4]), 32'(ac2 + 3));
        chk("starve_rdata", 32'(rd2), 32'hC3);
        chk("starve_cnt", 32'(dut.u_starve.count_q), 0);

        // back-to-back reads
        xfer(0, 1'b1, 12'h000, 8'h11, rd, n0, ac);
        xfer(0, 1'b1, 12'h001, 8'h22, rd, n0, ac);
        xfer(0, 1'b1, 12'h002, 8'h33, rd, n0, ac);
        n0 = cyc;
        cpu_stream(3, 12'h000);
        chk("b2b_first", 32'(st_ack[0] - n0), 2);
        chk("b2b_gap1", 32'(st_ack[1] - st_ack[0]), 3);
        chk("b2b_gap2", 32'(st_ack[2] - st_ack[1]), 3);
        chk("b2b_rd0", 32'(st_rd[0]), 32'h11);
        chk("b2b_rd1", 32'(st_rd[1]), 32'h22);
        chk("b2b_rd2", 32'(st_rd[2]), 32'h33);

        // reset during ACCESS of a DMA write
        nd0 = n_dack;
        dma_we = 1'b1; dma_addr = 12'hF10; dma_wdata = 8'h77; dma_req = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        dma_req = 1'b0;
        @(negedge clk);
        chk("rac_memreq", 32'(mem_memreq), 1);
        chk("rac_addr", 32'(mem_addr), 32'hF10);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rac_outs", 32'({cpu_ack, dma_ack, mem_we, mem_memreq}), 0);
        chk("rac_addr0", 32'({mem_addr, mem_data_in}), 0);
        repeat (3) @(negedge clk);
        chk("rac_no_ack", 32'(n_dack - nd0), 0);
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 12'hF10, 8'h00, rd, n0, ac);
        chk("rac_landed", 32'(rd), 32'h77);

        // idle
        nc0 = n_cack; nd0 = n_dack; n1 = n_busy;
        repeat (10) @(negedge clk);
        chk("idle_acks", 32'((n_cack - nc0) + (n_dack - nd0)), 0);
        chk("idle_busy", 32'(n_busy - n1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
